// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier: FSM states,
// index/accumulator width helpers and the signed saturation used by the MAC unit.
package matmul_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

    localparam int SAT_W = 128;

    // A dimension of 1 still needs a 1-bit port, so index widths never collapse to 0.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + $clog2(k) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_narrow(input logic signed [SAT_W-1:0] acc,
                                                            input int dw);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = 1;
        hi  = (one <<< (dw - 1)) - one;
        lo  = -hi - one;
        if (acc > hi)
            return hi;
        if (acc < lo)
            return lo;
        return acc;
    endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Signed multiply-accumulate with an ACC_W accumulator and the narrowing output stage.
// Narrowing wraps by default; defining PARAM_MATMUL_SATURATE_EN makes it saturate.
module matmul_mac_unit
    import matmul_pkg::*;
#(
    parameter int DW = 32,
    parameter int K  = 4,
    localparam int ACC_W = acc_width(DW, K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] z
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= acc + prod_ext;
    end

`ifdef PARAM_MATMUL_SATURATE_EN
    logic signed [SAT_W-1:0] acc_wide;

    assign acc_wide = {{(SAT_W - ACC_W){acc[ACC_W-1]}}, acc};
    assign z        = DW'(sat_narrow(acc_wide, DW));
`else
    assign z = acc[DW-1:0];
`endif

endmodule

// File: rtl/param_matrix_multiplier.sv
// Sequential Z = A x B (MxK times KxN): fetches one operand pair per cycle, emits
// results row-major over z_stb/z_ack. Optional saturation: PARAM_MATMUL_SATURATE_EN.
module param_matrix_multiplier
    import matmul_pkg::*;
#(
    parameter int M  = 4,
    parameter int K  = 4,
    parameter int N  = 4,
    parameter int DW = 32,
    localparam int MW = idx_w(M),
    localparam int KW = idx_w(K),
    localparam int NW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [MW-1:0] a_i,
    output logic [KW-1:0] a_j,
    output logic [KW-1:0] b_i,
    output logic [NW-1:0] b_j,
    output logic [DW-1:0] z_out,
    output logic [MW-1:0] z_i,
    output logic [NW-1:0] z_j,
    output logic          z_stb,
    input  logic          z_ack,
    output logic          done
);

    localparam logic [MW-1:0] M_LAST = MW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);

    state_t        state;
    logic [MW-1:0] row;
    logic [KW-1:0] k;
    logic [NW-1:0] col;
    logic          xfer;
    logic          acc_clear;
    logic          acc_en;

    assign xfer      = (state == OUT) && z_stb && z_ack;
    assign acc_clear = ((state == IDLE) && start) || xfer;
    assign acc_en    = (state == MAC);

    assign a_i = row;
    assign a_j = k;
    assign b_i = k;
    assign b_j = col;
    assign z_i = row;
    assign z_j = col;

    matmul_mac_unit #(
        .DW (DW),
        .K  (K)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .en    (acc_en),
        .a     (a_in),
        .b     (b_in),
        .z     (z_out)
    );

    // Ack only counts while z_stb is high, so a late/trailing ack cannot skip an element.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            k     <= '0;
            col   <= '0;
            z_stb <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row   <= '0;
                        k     <= '0;
                        col   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (k == K_LAST) begin
                        k     <= '0;
                        z_stb <= 1'b1;
                        state <= OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (xfer) begin
                        z_stb <= 1'b0;
                        k     <= '0;
                        if (col == N_LAST) begin
                            col <= '0;
                            if (row == M_LAST) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                row   <= row + 1'b1;
                                state <= MAC;
                            end
                        end else begin
                            col   <= col + 1'b1;
                            state <= MAC;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
